// File: rtl/hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO controller: FSM states and read-port select.
package hilo_ctrl_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    M_START = 3'd1,
    M_WAIT  = 3'd2,
    D_START = 3'd3,
    D_WAIT  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_HI   = 2'd1,
    SEL_LO   = 2'd2
  } rd_sel_t;

  // Read-port select from the op vector {mult, div, mthi, mtlo, mfhi, mflo}.
  // Any higher-priority op wins over a read, so the read is not served.
  function automatic rd_sel_t rd_select(input logic [5:0] ops);
    rd_sel_t sel;
    sel = SEL_NONE;
    if (ops[5:2] == 4'b0000) begin
      if (ops[1])      sel = SEL_HI;
      else if (ops[0]) sel = SEL_LO;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// HI/LO register owner: sequences mult/div units, stalls upstream while busy,
// serves MTHI/MTLO writes and MFHI/MFLO reads.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_mult,
  input  logic        op_div,
  input  logic        op_mthi,
  input  logic        op_mtlo,
  input  logic        op_mfhi,
  input  logic        op_mflo,
  input  logic [31:0] wr_data,
  input  logic        mult_end,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic        div_end,
  input  logic        div_zero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mult_start,
  output logic        div_start,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t               state, state_d;
  logic [TW-1:0]        timer, timer_d;
  logic [DATA_W-1:0]    hi_d, lo_d;
  logic                 timeout_d;
  logic [5:0]           ops;
  rd_sel_t              rd_sel;

  assign ops = {op_mult, op_div, op_mthi, op_mtlo, op_mfhi, op_mflo};

  // Upstream hold and read port (combinational by design).
  always_comb begin
    rd_sel  = rd_select(ops);
    stall   = (state != IDLE) && (ops != 6'b000000);
    rd_data = '0;
    case (rd_sel)
      SEL_HI:  rd_data = hi;
      SEL_LO:  rd_data = lo;
      default: rd_data = '0;
    endcase
  end

  // Next-state, HI/LO update and wait-timer logic.
  always_comb begin
    state_d   = state;
    hi_d      = hi;
    lo_d      = lo;
    timer_d   = timer;
    timeout_d = 1'b0;
    case (state)
      IDLE: begin
        // *_end levels are ignored here; only the priority winner is taken.
        if (op_mult) begin
          state_d = M_START;
          timer_d = '0;
        end else if (op_div) begin
          state_d = D_START;
          timer_d = '0;
        end else if (op_mthi) begin
          hi_d = wr_data;
        end else if (op_mtlo) begin
          lo_d = wr_data;
        end
      end
      // A stale *_end from the previous op is still high during START.
      M_START: state_d = M_WAIT;
      D_START: state_d = D_WAIT;
      M_WAIT: begin
        if (mult_end) begin
          state_d = IDLE;
          hi_d    = mult_hi;
          lo_d    = mult_lo;
        end else if (timer == TW'(TIMEOUT)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      D_WAIT: begin
        if (div_end) begin
          state_d = IDLE;
          if (!div_zero) begin
            hi_d = div_hi;
            lo_d = div_lo;
          end
        end else if (timer == TW'(TIMEOUT)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, architectural registers and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      hi          <= '0;
      lo          <= '0;
      mult_start  <= 1'b0;
      div_start   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      timer       <= timer_d;
      hi          <= hi_d;
      lo          <= lo_d;
      mult_start  <= (state_d == M_START);
      div_start   <= (state_d == D_START);
      timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural mult/div unit stubs, a transaction-level
// reference model checked every cycle, directed scenarios and random traffic.
module tb_hilo_ctrl;

  localparam int TIMEOUT = 63;

  localparam logic [5:0] OP_NONE = 6'b000000;
  localparam logic [5:0] OP_MULT = 6'b100000;
  localparam logic [5:0] OP_DIV  = 6'b010000;
  localparam logic [5:0] OP_MTHI = 6'b001000;
  localparam logic [5:0] OP_MTLO = 6'b000100;
  localparam logic [5:0] OP_MFHI = 6'b000010;
  localparam logic [5:0] OP_MFLO = 6'b000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_mult = 1'b0, op_div = 1'b0, op_mthi = 1'b0;
  logic        op_mtlo = 1'b0, op_mfhi = 1'b0, op_mflo = 1'b0;
  logic [31:0] wr_data = '0;
  logic        mult_end = 1'b0;
  logic [31:0] mult_hi = '0, mult_lo = '0;
  logic        div_end = 1'b0, div_zero = 1'b0;
  logic [31:0] div_hi = '0, div_lo = '0;
  logic        mult_start, div_start, stall, timeout_err;
  logic [31:0] rd_data, hi, lo;

  hilo_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .op_mult(op_mult), .op_div(op_div), .op_mthi(op_mthi),
    .op_mtlo(op_mtlo), .op_mfhi(op_mfhi), .op_mflo(op_mflo),
    .wr_data(wr_data),
    .mult_end(mult_end), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_end(div_end), .div_zero(div_zero), .div_hi(div_hi), .div_lo(div_lo),
    .mult_start(mult_start), .div_start(div_start), .stall(stall),
    .rd_data(rd_data), .hi(hi), .lo(lo), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Operands and unit latencies chosen by the stimulus.
  logic [31:0] m_a = '0, m_b = '0, d_a = '0, d_b = '0;
  int          mlat = 1, dlat = 1;
  bit          div_never = 1'b0;

  // Operands of the op in flight, latched by the model at acceptance.
  logic [31:0] cap_a = '0, cap_b = '0;

  // Multiplier stub: end level drops on start, rises after mlat cycles.
  int          m_cnt = 0;
  logic [63:0] m_res = '0;
  always @(posedge clk) begin
    if (mult_start) begin
      mult_end <= 1'b0;
      m_cnt    <= mlat;
      m_res    <= 64'(longint'($signed(cap_a)) * longint'($signed(cap_b)));
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mult_end <= 1'b1;
        mult_hi  <= m_res[63:32];
        mult_lo  <= m_res[31:0];
      end
    end
  end

  // Divider stub: same handshake; can be told never to finish.
  int          d_cnt = 0;
  logic        d_z = 1'b0;
  logic [31:0] d_q = '0, d_r = '0;
  always @(posedge clk) begin
    if (div_start) begin
      div_end <= 1'b0;
      d_cnt   <= div_never ? 0 : dlat;
      d_z     <= (cap_b == 32'd0);
      d_q     <= (cap_b == 32'd0) ? 32'hDEAD_BEEF : cap_a / cap_b;
      d_r     <= (cap_b == 32'd0) ? 32'hBAD0_BAD0 : cap_a % cap_b;
    end else if (d_cnt > 0) begin
      d_cnt <= d_cnt - 1;
      if (d_cnt == 1) begin
        div_end  <= 1'b1;
        div_zero <= d_z;
        div_hi   <= d_r;
        div_lo   <= d_q;
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;
  int ms_count = 0;

  // Reference model: busy kind (0 none, 1 mult, 2 div) and age in cycles since
  // acceptance (age 1 is the start-pulse cycle; later ages are wait cycles).
  int          m_busy = 0;
  int          m_age  = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] res_hi = '0, res_lo = '0;
  bit          res_keep = 1'b0;
  bit          m_terr = 1'b0;

  function automatic logic [5:0] ops_now();
    return {op_mult, op_div, op_mthi, op_mtlo, op_mfhi, op_mflo};
  endfunction

  // 0 mult, 1 div, 2 mthi, 3 mtlo, 4 mfhi, 5 mflo, 6 none.
  function automatic int winner(input logic [5:0] v);
    for (int i = 5; i >= 0; i--) if (v[i]) return 5 - i;
    return 6;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [5:0] v);
    {op_mult, op_div, op_mthi, op_mtlo, op_mfhi, op_mflo} = v;
  endtask

  // Compare DUT against the model, then advance the model across the next edge.
  task automatic monitor_step();
    logic [5:0]  v;
    int          w;
    logic [31:0] exp_rd;
    logic [63:0] p;
    v = ops_now();
    w = winner(v);
    exp_rd = (w == 4) ? m_hi : (w == 5) ? m_lo : 32'd0;
    if (mon_en) begin
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("stall", 32'(stall), 32'((m_busy != 0) && (v != OP_NONE)));
      chk("rd_data", rd_data, exp_rd);
      chk("mult_start", 32'(mult_start), 32'((m_busy == 1) && (m_age == 1)));
      chk("div_start", 32'(div_start), 32'((m_busy == 2) && (m_age == 1)));
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    end
    if (mult_start === 1'b1) ms_count++;
    m_terr = 1'b0;
    if (rst) begin
      m_busy = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_busy == 0) begin
      case (w)
        0: begin
          cap_a = m_a; cap_b = m_b;
          p = 64'(longint'($signed(m_a)) * longint'($signed(m_b)));
          res_hi = p[63:32]; res_lo = p[31:0]; res_keep = 1'b0;
          m_busy = 1; m_age = 1;
        end
        1: begin
          cap_a = d_a; cap_b = d_b;
          res_keep = (d_b == 32'd0);
          if (!res_keep) begin res_hi = d_a % d_b; res_lo = d_a / d_b; end
          m_busy = 2; m_age = 1;
        end
        2: m_hi = wr_data;
        3: m_lo = wr_data;
        default: ;
      endcase
    end else if (m_age == 1) begin
      m_age = 2;
    end else begin
      if ((m_busy == 1) ? mult_end : div_end) begin
        if (!res_keep) begin m_hi = res_hi; m_lo = res_lo; end
        m_busy = 0;
      end else if (m_age - 2 == TIMEOUT) begin
        m_busy = 0;
        m_terr = 1'b1;
      end else begin
        m_age++;
      end
    end
  endtask

  // Hold the current op until stall drops, with a cycle budget.
  task automatic wait_unstall(input string nm, output int n);
    n = 0;
    #1;
    while (stall !== 1'b0 && n < 300) begin
      tick();
      #1;
      n++;
    end
    if (stall !== 1'b0) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: stall still %b after %0d cycles, expected 0", nm, stall, n);
    end
  endtask

  task automatic pick_random();
    int r;
    r = int'($urandom_range(0, 99));
    wr_data = $urandom;
    m_a = $urandom; m_b = $urandom;
    d_a = $urandom;
    d_b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
    mlat = int'($urandom_range(1, 8));
    dlat = int'($urandom_range(1, 8));
    if      (r < 30) put(OP_NONE);
    else if (r < 45) put(OP_MULT);
    else if (r < 60) put(OP_DIV);
    else if (r < 70) put(OP_MTHI);
    else if (r < 80) put(OP_MTLO);
    else if (r < 88) put(OP_MFHI);
    else if (r < 96) put(OP_MFLO);
    else             put(6'($urandom));
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      begin : stim
        int n;
        bit s;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mult_start", 32'(mult_start), 32'd0);

        // MULT -7 * 6 with a held MFHI behind it.
        m_a = 32'hFFFF_FFF9; m_b = 32'd6; mlat = 3;
        put(OP_MULT);
        tick();
        put(OP_MFHI);
        wait_unstall("mult1", n);
        chk("mult1_stall_cycles", 32'(n), 32'd5);
        chk("mult1_rd_new_hi", rd_data, 32'hFFFF_FFFF);
        chk("mult1_hi", hi, 32'hFFFF_FFFF);
        chk("mult1_lo", lo, 32'hFFFF_FFD6);
        chk("mult1_start_pulses", 32'(ms_count), 32'd1);
        tick();

        // Back-to-back MULT while mult_end is still high from the first.
        m_a = 32'd3; m_b = 32'd5; mlat = 4;
        put(OP_MULT);
        tick();
        put(OP_MFLO);
        wait_unstall("mult2", n);
        chk("mult2_rd_lo", rd_data, 32'd15);
        chk("mult2_hi", hi, 32'd0);
        tick();

        // MTHI then MFHI in the next cycle.
        wr_data = 32'h1234_5678;
        put(OP_MTHI);
        tick();
        put(OP_MFHI);
        #1;
        chk("mthi_rd", rd_data, 32'h1234_5678);
        chk("mthi_stall", 32'(stall), 32'd0);
        tick();

        // DIV 100 / 7, then DIV by zero which must leave HI/LO alone.
        d_a = 32'd100; d_b = 32'd7; dlat = 2;
        put(OP_DIV);
        tick();
        put(OP_MFLO);
        wait_unstall("div1", n);
        chk("div1_lo", lo, 32'd14);
        chk("div1_hi", hi, 32'd2);
        tick();
        d_a = 32'd100; d_b = 32'd0; dlat = 2;
        put(OP_DIV);
        tick();
        put(OP_MFHI);
        wait_unstall("divz", n);
        chk("divz_hi", hi, 32'd2);
        chk("divz_lo", lo, 32'd14);
        tick();

        // Divider that never finishes: abort after TIMEOUT+1 wait cycles.
        div_never = 1'b1;
        put(OP_DIV);
        tick();
        put(OP_NONE);
        n = 1;
        while (timeout_err !== 1'b1 && n < 200) begin
          tick();
          n++;
        end
        // 1 start cycle + 64 wait cycles, pulse in the following cycle.
        chk("timeout_cycle", 32'(n), 32'(TIMEOUT + 3));
        chk("timeout_hi", hi, 32'd2);
        chk("timeout_lo", lo, 32'd14);
        div_never = 1'b0;
        tick();

        // Random traffic; a stalled op is re-presented until accepted.
        put(OP_NONE);
        #1;
        for (int i = 0; i < 1500; i++) begin
          s = stall;
          tick();
          if (!s) pick_random();
          #1;
        end
        put(OP_MFHI);
        wait_unstall("drain", n);
        tick();

        // Reset in M_WAIT aborts the op; the late mult_end is ignored.
        wr_data = 32'hA5A5_A5A5;
        put(OP_MTHI);
        tick();
        m_a = 32'd2; m_b = 32'd3; mlat = 10;
        put(OP_MULT);
        tick();
        put(OP_NONE);
        tick();
        tick();
        rst = 1'b1;
        put(OP_MFHI);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        put(OP_NONE);
        repeat (15) tick();
        chk("rstmid_late_end_hi", hi, 32'd0);
        chk("rstmid_late_end_lo", lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
      end
    join
  end

endmodule
